// File: rtl/zjh_counter_mod_n_if.sv
// Control/data bundle for zjh_counter_mod_n: loads, enables, mode pins and the count/terminal outputs.
// The master drives the controls and D; the counter (slave) returns Q and TC.
interface zjh_counter_mod_n_if #(
    parameter int WIDTH = 4
);
    logic             SR;
    logic             PE;
    logic             Cep;
    logic             Cet;
    logic             UD;
    logic             SAT;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;

    modport master (
        output SR, PE, Cep, Cet, UD, SAT, D,
        input  Q, TC
    );

    modport slave (
        input  SR, PE, Cep, Cet, UD, SAT, D,
        output Q, TC
    );
endinterface

// File: rtl/zjh_counter_mod_n.sv
// Synchronous modulo-N up/down counter with clear, clamped parallel load, saturate mode
// and a 74HC161-style Cep/Cet enable pair with a cascadable terminal-count output.
module zjh_counter_mod_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic                Clk,
    input  logic                MR,
    zjh_counter_mod_n_if.slave  bus
);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("zjh_counter_mod_n: WIDTH must be in 2..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("zjh_counter_mod_n: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT
    } op_e;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_val;
    logic             at_max;
    logic             at_zero;
    op_e              op;

    assign at_max  = (q == Q_MAX);
    assign at_zero = (q == '0);

    // Priority decode of the edge action: clear beats load beats count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        op = OP_HOLD;
        if (!bus.SR) begin
            op = OP_CLEAR;
        end else if (!bus.PE) begin
            op = OP_LOAD;
        end else if (bus.Cep && bus.Cet) begin
            op = OP_COUNT;
        end
    end

    // Out-of-range load data is clamped so Q never leaves 0..MODULUS-1.
    always_comb begin
        load_val = Q_MAX;
        if ({1'b0, bus.D} < MOD_EXT) begin
            load_val = bus.D;
        end
    end

    // q+1 is only taken below Q_MAX and q-1 only above zero, so neither can overflow WIDTH.
    always_comb begin
        count_val = q;
        if (bus.UD) begin
            if (!at_max) begin
                count_val = q + WIDTH'(1);
            end else if (!bus.SAT) begin
                count_val = '0;
            end
        end else begin
            if (!at_zero) begin
                count_val = q - WIDTH'(1);
            end else if (!bus.SAT) begin
                count_val = Q_MAX;
            end
        end
    end

    always_comb begin
        q_next = q;
        unique case (op)
            OP_CLEAR: q_next = '0;
            OP_LOAD:  q_next = load_val;
            OP_COUNT: q_next = count_val;
            default:  q_next = q;
        endcase
    end

    always_ff @(posedge Clk or negedge MR) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (!MR) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign bus.Q  = q;
    // TC ignores Cep and follows UD/Cet combinationally so it can drive the next stage's Cet.
    assign bus.TC = bus.Cet & (bus.UD ? at_max : at_zero);

endmodule

// File: tb/tb_zjh_counter_mod_n.sv
// Self-checking bench: a mod-10 counter checked against an arithmetic model every cycle,
// plus a two-stage mod-16 cascade checked as a single 8-bit counter.
module tb_zjh_counter_mod_n;

    localparam int W = 4;
    localparam int M = 10;

    logic Clk = 1'b0;
    logic MR  = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mq    = 0;
    int   cq    = 0;

    always #5 Clk = ~Clk;

    zjh_counter_mod_n_if #(.WIDTH(W)) m_if ();
    zjh_counter_mod_n_if #(.WIDTH(4)) c0_if ();
    zjh_counter_mod_n_if #(.WIDTH(4)) c1_if ();

    zjh_counter_mod_n #(.WIDTH(W), .MODULUS(M))  dut (.Clk(Clk), .MR(MR), .bus(m_if.slave));
    zjh_counter_mod_n #(.WIDTH(4), .MODULUS(16)) u_c0 (.Clk(Clk), .MR(MR), .bus(c0_if.slave));
    zjh_counter_mod_n #(.WIDTH(4), .MODULUS(16)) u_c1 (.Clk(Clk), .MR(MR), .bus(c1_if.slave));

    assign c1_if.Cet = c0_if.TC;
    assign c1_if.SR  = c0_if.SR;
    assign c1_if.PE  = c0_if.PE;
    assign c1_if.Cep = c0_if.Cep;
    assign c1_if.UD  = c0_if.UD;
    assign c1_if.SAT = c0_if.SAT;
    assign c1_if.D   = c0_if.D;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mod-10 reference: what Q must be after each edge, from the counting rules.
    always @(posedge Clk or negedge MR) begin
        if (!MR) begin
            mq = 0;
        end else if (!m_if.SR) begin
            mq = 0;
        end else if (!m_if.PE) begin
            mq = (int'(m_if.D) < M) ? int'(m_if.D) : M - 1;
        end else if (m_if.Cep && m_if.Cet) begin
            if (m_if.UD) mq = (m_if.SAT && mq == M - 1) ? mq : (mq + 1) % M;
            else         mq = (m_if.SAT && mq == 0)     ? mq : (mq + M - 1) % M;
        end
    end

    // Cascade reference: the pair behaves as one wrapping 8-bit counter.
    always @(posedge Clk or negedge MR) begin
        if (!MR || !c0_if.SR) begin
            cq = 0;
        end else if (c0_if.Cep && c0_if.Cet) begin
            cq = c0_if.UD ? (cq + 1) % 256 : (cq + 255) % 256;
        end
    end

    always @(negedge Clk) begin
        int m_tc;
        int c_tc;
        m_tc = (m_if.Cet && (m_if.UD ? (mq == M - 1) : (mq == 0))) ? 1 : 0;
        c_tc = (c0_if.Cet && (c0_if.UD ? (cq == 255) : (cq == 0))) ? 1 : 0;
        check("model_q", int'(m_if.Q), mq);
        check("model_tc", int'(m_if.TC), m_tc);
        check("cascade_q", int'({c1_if.Q, c0_if.Q}), cq);
        check("cascade_tc", int'(c1_if.TC), c_tc);
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_if.SR = 1'b1; m_if.PE = 1'b1; m_if.Cep = 1'b0; m_if.Cet = 1'b0;
        m_if.UD = 1'b1; m_if.SAT = 1'b0; m_if.D = '0;
        c0_if.SR = 1'b0; c0_if.PE = 1'b1; c0_if.Cep = 1'b1; c0_if.Cet = 1'b1;
        c0_if.UD = 1'b1; c0_if.SAT = 1'b0; c0_if.D = '0;

        // Reset state and asynchronous clear mid-cycle
        tick();
        tick();
        check("reset_q", int'(m_if.Q), 0);
        MR = 1'b1;
        m_if.PE = 1'b0; m_if.D = 4'd7;
        tick();
        check("load7", int'(m_if.Q), 7);
        m_if.PE = 1'b1;
        #1 MR = 1'b0;
        #1 check("async_clear", int'(m_if.Q), 0);
        m_if.UD = 1'b0; m_if.Cet = 1'b1;
        #1 check("tc_in_reset", int'(m_if.TC), 1);
        tick();
        MR = 1'b1;
        m_if.UD = 1'b1; m_if.Cep = 1'b1; m_if.Cet = 1'b1;
        tick();
        check("first_edge", int'(m_if.Q), 1);

        // Up wrap 0..9,0 with TC only at 9
        m_if.SR = 1'b0;
        tick();
        check("sync_clear", int'(m_if.Q), 0);
        m_if.SR = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("up_seq", int'(m_if.Q), i);
            check("up_tc", int'(m_if.TC), (i == 9) ? 1 : 0);
        end
        m_if.Cet = 1'b0;
        #1 check("tc_cet_low", int'(m_if.TC), 0);
        tick();
        check("hold_cet_low", int'(m_if.Q), 9);
        m_if.UD = 1'b0; m_if.Cet = 1'b1;
        #1 check("tc_ud_toggle", int'(m_if.TC), 0);
        m_if.UD = 1'b1;
        tick();
        check("up_wrap", int'(m_if.Q), 0);

        // Down with saturate, then wrap
        m_if.UD = 1'b0; m_if.SAT = 1'b1; m_if.PE = 1'b0; m_if.D = 4'd2;
        tick();
        check("load2", int'(m_if.Q), 2);
        m_if.PE = 1'b1;
        tick(); check("down1", int'(m_if.Q), 1);
        tick(); check("down0", int'(m_if.Q), 0);
        check("down_tc", int'(m_if.TC), 1);
        tick(); check("sat_hold_a", int'(m_if.Q), 0);
        tick(); check("sat_hold_b", int'(m_if.Q), 0);
        check("sat_tc", int'(m_if.TC), 1);
        m_if.SAT = 1'b0;
        tick();
        check("down_wrap", int'(m_if.Q), 9);

        // Priority and clamp
        m_if.SR = 1'b0; m_if.PE = 1'b0; m_if.D = 4'd5;
        tick();
        check("sr_over_pe", int'(m_if.Q), 0);
        m_if.SR = 1'b1; m_if.D = 4'd13;
        tick();
        check("load_clamp", int'(m_if.Q), 9);
        m_if.Cep = 1'b0; m_if.Cet = 1'b0; m_if.D = 4'd4;
        tick();
        check("load_no_en", int'(m_if.Q), 4);

        // Enable gating at Q=9
        m_if.D = 4'd9;
        tick();
        m_if.PE = 1'b1; m_if.UD = 1'b1; m_if.Cep = 1'b0; m_if.Cet = 1'b1;
        tick();
        check("cep_low_q", int'(m_if.Q), 9);
        check("cep_low_tc", int'(m_if.TC), 1);
        m_if.Cep = 1'b1; m_if.Cet = 1'b0;
        tick();
        check("cet_low_q", int'(m_if.Q), 9);
        check("cet_low_tc", int'(m_if.TC), 0);

        // Two-stage cascade counts to 8'hFF and wraps
        tick();
        c0_if.SR = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("cascade_ff", int'({c1_if.Q, c0_if.Q}), 255);
        check("cascade_tc1", int'(c1_if.TC), 1);
        tick();
        check("cascade_wrap", int'({c1_if.Q, c0_if.Q}), 0);
        check("cascade_tc1_off", int'(c1_if.TC), 0);

        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
